// File: rtl/jtkicker_objscan.sv
// Kicker object RAM (two CPU-writable banks) and per-line sprite scanner.
// Each sprite hitting the next line becomes one valid/ready draw request.
module jtkicker_objscan #(
   parameter int OBJMAX = 24,
   parameter int AW     = 10
)(
   input  logic          clk,
   input  logic          rstn,
   input  logic          cpu_cen,
   input  logic [AW-1:0] cpu_addr,
   input  logic [7:0]    cpu_dout,
   input  logic          cpu_rnw,
   input  logic          obj1_cs,
   input  logic          obj2_cs,
   output logic [7:0]    obj_dout,
   input  logic          hs,
   input  logic [7:0]    vrender,
   input  logic          flip,
   output logic          dr_valid,
   input  logic          dr_ready,
   output logic [7:0]    dr_code,
   output logic [3:0]    dr_pal,
   output logic          dr_hflip,
   output logic [8:0]    dr_xpos,
   output logic [3:0]    dr_ysub,
   output logic          line_done
);

   localparam int IW = (OBJMAX > 1) ? $clog2(OBJMAX) : 1;

   typedef enum logic [2:0] {IDLE, RD0, RD1, CHK, REQ, NEXT} state_t;

   state_t          state, nxt;
   logic [7:0]      ram1 [0:2**AW-1];
   logic [7:0]      ram2 [0:2**AW-1];
   logic [7:0]      q1, q2;
   logic [AW-1:0]   scan_addr;
   logic [IW-1:0]   idx;
   logic            hs_l, hs_rise, last_ent;
   logic [7:0]      code_r;
   logic [3:0]      pal_r;
   logic            hf_r, vf_r, xhi_r;
   logic [7:0]      v, d;
   logic [8:0]      xfull;
   logic            hit;

   assign hs_rise = hs & ~hs_l;

   always_ff @(posedge clk) begin
      if (cpu_cen && !cpu_rnw && obj1_cs) ram1[cpu_addr] <= cpu_dout;
      if (cpu_cen && !cpu_rnw && obj2_cs) ram2[cpu_addr] <= cpu_dout;
   end

   // Scanner port: registered read, so a same-cycle CPU write is not seen
   assign scan_addr = AW'({idx, state == RD1});

   always_ff @(posedge clk) begin
      q1 <= ram1[scan_addr];
      q2 <= ram2[scan_addr];
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) obj_dout <= 8'd0;
      else       obj_dout <= obj1_cs ? ram1[cpu_addr] : ram2[cpu_addr];
   end

   // During CHK, q1 holds y and q2 holds x[7:0]
   assign v     = flip ? ~vrender : vrender;
   assign d     = v - q1;
   assign hit   = (d < 8'd16) && (q1 != 8'd0);
   assign xfull = {xhi_r, q2};

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= IDLE;
      else       state <= nxt;
   end

   always_comb begin
      nxt = state;
      case (state)
         IDLE:    nxt = IDLE;
         RD0:     nxt = RD1;
         RD1:     nxt = CHK;
         CHK:     nxt = hit ? REQ : NEXT;
         REQ:     nxt = dr_ready ? NEXT : REQ;
         NEXT:    nxt = (idx == '0) ? IDLE : RD0;
         default: nxt = IDLE;
      endcase
      if (hs_rise) nxt = RD0;
   end

   always_comb begin
      dr_valid = (state == REQ);
      last_ent = (state == NEXT) && (idx == '0);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         hs_l      <= 1'b0;
         line_done <= 1'b0;
         idx       <= '0;
         code_r    <= 8'd0;
         pal_r     <= 4'd0;
         hf_r      <= 1'b0;
         vf_r      <= 1'b0;
         xhi_r     <= 1'b0;
         dr_code   <= 8'd0;
         dr_pal    <= 4'd0;
         dr_hflip  <= 1'b0;
         dr_xpos   <= 9'd0;
         dr_ysub   <= 4'd0;
      end else begin
         hs_l      <= hs;
         line_done <= last_ent & ~hs_rise;
         if (hs_rise)
            idx <= IW'(OBJMAX-1);
         else if (state == NEXT && idx != '0)
            idx <= idx - IW'(1);
         if (state == RD1) begin
            code_r <= q1;
            pal_r  <= q2[3:0];
            hf_r   <= q2[6];
            vf_r   <= q2[5];
            xhi_r  <= q2[7];
         end
         // Fields only load in CHK, so they hold while a request stalls
         if (state == CHK) begin
            dr_code  <= code_r;
            dr_pal   <= pal_r;
            dr_hflip <= hf_r ^ flip;
            dr_xpos  <= flip ? 9'h1FF - xfull : xfull;
            dr_ysub  <= d[3:0] ^ {4{vf_r}};
         end
      end
   end

endmodule

// File: tb/tb_jtkicker_objscan.sv
// Bench for jtkicker_objscan: RAM mirror + sprite-rule model, cycle-level request monitor.
module tb_jtkicker_objscan;

   localparam int OBJMAX = 24;
   localparam int AW     = 10;

   logic          clk = 0, rstn = 0;
   logic          cpu_cen = 0, cpu_rnw = 1, obj1_cs = 0, obj2_cs = 0;
   logic [AW-1:0] cpu_addr = '0;
   logic [7:0]    cpu_dout = 0;
   logic [7:0]    obj_dout;
   logic          hs = 0, flip = 0, dr_ready = 0;
   logic [7:0]    vrender = 0;
   logic          dr_valid, dr_hflip, line_done;
   logic [7:0]    dr_code;
   logic [3:0]    dr_pal, dr_ysub;
   logic [8:0]    dr_xpos;

   jtkicker_objscan #(.OBJMAX(OBJMAX), .AW(AW)) dut (
      .clk(clk), .rstn(rstn), .cpu_cen(cpu_cen), .cpu_addr(cpu_addr),
      .cpu_dout(cpu_dout), .cpu_rnw(cpu_rnw), .obj1_cs(obj1_cs), .obj2_cs(obj2_cs),
      .obj_dout(obj_dout), .hs(hs), .vrender(vrender), .flip(flip),
      .dr_valid(dr_valid), .dr_ready(dr_ready), .dr_code(dr_code), .dr_pal(dr_pal),
      .dr_hflip(dr_hflip), .dr_xpos(dr_xpos), .dr_ysub(dr_ysub), .line_done(line_done)
   );

   always #5 clk = ~clk;

   typedef struct {
      int code; int pal; int hflip; int xpos; int ysub; int k;
   } req_t;

   int   errors = 0, checks = 0;
   int   cyc = 0;
   logic [7:0] m1 [0:2**AW-1];
   logic [7:0] m2 [0:2**AW-1];
   req_t expq[$];
   int   acc_code[$];
   req_t last_acc;
   int   t_hs = 0, extra = 0, active = 0, holding = 0;
   int   done_cnt = 0, last_done_dt = 0, stall_cnt = 0;
   int   h_code, h_pal, h_hflip, h_xpos, h_ysub;
   int   rdy_mode = 0;
   logic rdy_val = 0;

   always @(posedge clk) cyc++;

   always @(posedge clk) begin
      #2;
      dr_ready = rdy_mode ? 1'($urandom_range(0, 1)) : rdy_val;
   end

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic fail(input string nm);
      checks++;
      errors++;
      $display("FAIL %s (cycle %0d)", nm, cyc);
   endtask

   // Expected requests for one line, straight from the sprite rules
   task automatic build_model(input int vr, input int fl);
      expq.delete();
      for (int k = OBJMAX-1; k >= 0; k--) begin
         int y, v, dd, attr, xp;
         req_t r;
         y    = int'(m1[2*k+1]);
         attr = int'(m2[2*k]);
         v    = fl ? 255 - vr : vr;
         dd   = (v - y + 256) % 256;
         if (dd < 16 && y != 0) begin
            xp      = ((attr >> 7) & 1) * 256 + int'(m2[2*k+1]);
            r.code  = int'(m1[2*k]);
            r.pal   = attr % 16;
            r.hflip = ((attr >> 6) & 1) ^ fl;
            r.xpos  = fl ? 511 - xp : xp;
            r.ysub  = ((attr >> 5) & 1) ? 15 - dd : dd;
            r.k     = k;
            expq.push_back(r);
         end
      end
   endtask

   // Request timing: 1 clock edge-detect, 4 clocks per entry, +1 per cycle spent in REQ
   always @(negedge clk) begin
      if (rstn && active && cyc != t_hs) begin
         if (dr_valid) begin
            if (!holding) begin
               if (expq.size() == 0) fail("unexpected_request");
               else begin
                  chk("req_cycle", cyc, t_hs + 4 + 4*(OBJMAX-1-expq[0].k) + extra);
                  chk("req_code",  int'(dr_code),  expq[0].code);
                  chk("req_pal",   int'(dr_pal),   expq[0].pal);
                  chk("req_hflip", int'(dr_hflip), expq[0].hflip);
                  chk("req_xpos",  int'(dr_xpos),  expq[0].xpos);
                  chk("req_ysub",  int'(dr_ysub),  expq[0].ysub);
               end
               h_code = dr_code; h_pal = dr_pal; h_hflip = dr_hflip;
               h_xpos = dr_xpos; h_ysub = dr_ysub;
               holding = 1;
            end else begin
               chk("stable_fields", {h_code, h_pal, h_hflip, h_xpos, h_ysub},
                   {int'(dr_code), int'(dr_pal), int'(dr_hflip), int'(dr_xpos), int'(dr_ysub)});
            end
            extra++;
            if (dr_ready) begin
               acc_code.push_back(int'(dr_code));
               last_acc.code = dr_code; last_acc.pal = dr_pal; last_acc.hflip = dr_hflip;
               last_acc.xpos = dr_xpos; last_acc.ysub = dr_ysub;
               if (expq.size() != 0) void'(expq.pop_front());
               holding = 0;
            end else stall_cnt++;
         end else if (holding) begin
            fail("valid_dropped_before_accept");
            holding = 0;
         end
         if (line_done) begin
            chk("done_cycle", cyc, t_hs + 4*OBJMAX + 1 + extra);
            chk("done_queue_empty", expq.size(), 0);
            done_cnt++;
            last_done_dt = cyc - t_hs;
            active = 0;
         end
      end else if (rstn && !active && (dr_valid || line_done)) begin
         fail("output_while_idle");
      end
   end

   task automatic cpu_wr(input int bank, input int addr, input int data, input logic cen = 1);
      @(posedge clk); #1;
      cpu_addr = AW'(addr); cpu_dout = 8'(data); cpu_rnw = 0; cpu_cen = cen;
      obj1_cs = (bank == 1); obj2_cs = (bank == 2);
      if (cen) begin
         if (bank == 1) m1[addr] = 8'(data); else m2[addr] = 8'(data);
      end
      @(posedge clk); #1;
      cpu_cen = 0; cpu_rnw = 1; obj1_cs = 0; obj2_cs = 0;
   endtask

   task automatic cpu_rd_chk(input string nm, input int bank, input int addr, input int exp);
      @(posedge clk); #1;
      cpu_addr = AW'(addr); cpu_rnw = 1; obj1_cs = (bank == 1); obj2_cs = (bank == 2);
      @(negedge clk);
      @(negedge clk);
      chk(nm, int'(obj_dout), exp);
      obj1_cs = 0; obj2_cs = 0;
   endtask

   task automatic set_entry(input int k, input int code, input int y, input int attr, input int x);
      cpu_wr(1, 2*k, code);
      cpu_wr(1, 2*k+1, y);
      cpu_wr(2, 2*k, attr);
      cpu_wr(2, 2*k+1, x);
   endtask

   task automatic clear_table();
      for (int k = 0; k < OBJMAX; k++) set_entry(k, 0, 0, 0, 0);
   endtask

   task automatic start_scan(input int vr, input int fl);
      @(posedge clk); #1;
      vrender = 8'(vr); flip = fl[0];
      build_model(vr, fl);
      t_hs = cyc; extra = 0; holding = 0; active = 1;
      hs = 1;
      @(posedge clk); #1;
      hs = 0;
   endtask

   task automatic wait_done(input string nm, input int maxc);
      int d0 = done_cnt;
      for (int i = 0; i < maxc && done_cnt == d0; i++) @(posedge clk);
      #1;
      if (done_cnt == d0) begin
         fail({nm, "_timeout"});
         active = 0;
      end
   endtask

   task automatic wait_valid(input string nm, input int maxc);
      int seen = 0;
      for (int i = 0; i < maxc && !seen; i++) begin
         @(negedge clk);
         if (dr_valid) seen = 1;
      end
      if (!seen) fail({nm, "_timeout"});
   endtask

   initial begin
      int n0, d0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_obj_dout", int'(obj_dout), 0);
      chk("rst_valid", int'(dr_valid), 0);
      chk("rst_done", int'(line_done), 0);
      chk("rst_fields", int'({dr_code, dr_pal, dr_hflip, dr_xpos, dr_ysub}), 0);
      rstn = 1;
      @(negedge clk);
      chk("post_rst_valid", int'(dr_valid), 0);

      // CPU write / readback, including a write with cpu_cen low
      cpu_wr(1, 'h011, 'h5A);
      cpu_wr(2, 'h011, 'hA5);
      cpu_rd_chk("rd_bank1", 1, 'h011, 'h5A);
      cpu_rd_chk("rd_bank2", 2, 'h011, 'hA5);
      cpu_wr(1, 'h011, 'h33, 1'b0);
      cpu_rd_chk("rd_no_cen", 1, 'h011, 'h5A);
      for (int i = 0; i < 6; i++) begin
         int a = $urandom_range('h100, 'h3FF);
         cpu_wr(1, a, $urandom_range(0, 255));
         cpu_wr(2, a, $urandom_range(0, 255));
         cpu_rd_chk("rd_rand1", 1, a, int'(m1[a]));
         cpu_rd_chk("rd_rand2", 2, a, int'(m2[a]));
      end

      // Empty table
      clear_table();
      rdy_val = 1;
      start_scan('h45, 0);
      wait_done("empty", 300);
      chk("empty_done_dt", last_done_dt, 97);

      // Single hit
      set_entry(3, 'h12, 'h40, 'h05, 'h80);
      n0 = acc_code.size();
      start_scan('h45, 0);
      chk("model_single_cnt", expq.size(), 1);
      chk("model_single_xpos", expq[0].xpos, 'h080);
      chk("model_single_ysub", expq[0].ysub, 5);
      wait_done("single", 300);
      chk("single_cnt", acc_code.size() - n0, 1);
      chk("single_code", last_acc.code, 'h12);
      chk("single_pal", last_acc.pal, 5);
      chk("single_xpos", last_acc.xpos, 'h080);
      chk("single_ysub", last_acc.ysub, 5);
      chk("single_hflip", last_acc.hflip, 0);

      // vflip, hflip and screen flip
      set_entry(3, 'h12, 'h40, 'h65, 'h80);
      start_scan('hBA, 1);
      chk("model_flip_ysub", expq[0].ysub, 10);
      wait_done("flip", 300);
      chk("flip_ysub", last_acc.ysub, 10);
      chk("flip_hflip", last_acc.hflip, 0);
      chk("flip_xpos", last_acc.xpos, 'h17F);

      // Backpressure with two hits
      clear_table();
      set_entry(5, 'h55, 'h40, 'h03, 'h10);
      set_entry(2, 'h22, 'h44, 'h87, 'h20);
      rdy_val = 0; stall_cnt = 0;
      n0 = acc_code.size();
      start_scan('h45, 0);
      wait_valid("bp_valid", 200);
      repeat (20) @(posedge clk);
      #1 rdy_val = 1;
      wait_done("bp", 300);
      chk("bp_cnt", acc_code.size() - n0, 2);
      if (acc_code.size() - n0 == 2) begin
         chk("bp_first", acc_code[n0], 'h55);
         chk("bp_second", acc_code[n0+1], 'h22);
      end
      chk("bp_stalled", int'(stall_cnt >= 20), 1);

      // Abort in REQ: second hs edge restarts the scan
      clear_table();
      set_entry(3, 'h12, 'h40, 'h05, 'h80);
      rdy_val = 0;
      d0 = done_cnt; n0 = acc_code.size();
      start_scan('h45, 0);
      wait_valid("abort_valid", 200);
      repeat (3) @(posedge clk);
      start_scan('h45, 0);
      @(negedge clk);
      chk("abort_valid_low", int'(dr_valid), 0);
      @(posedge clk); #1 rdy_val = 1;
      wait_done("abort", 300);
      repeat (5) @(posedge clk);
      chk("abort_one_done", done_cnt - d0, 1);
      chk("abort_one_req", acc_code.size() - n0, 1);

      // Randomised tables, line numbers, flip and ready pattern
      for (int s = 0; s < 6; s++) begin
         int vr = $urandom_range(0, 255);
         int fl = $urandom_range(0, 1);
         int v  = fl ? 255 - vr : vr;
         for (int k = 0; k < OBJMAX; k++) begin
            int y = ($urandom_range(0, 3) == 0) ? 0 : (v - $urandom_range(0, 24) + 256) % 256;
            set_entry(k, $urandom_range(0, 255), y, $urandom_range(0, 255), $urandom_range(0, 255));
         end
         rdy_mode = 1;
         start_scan(vr, fl);
         wait_done("rand", 1000);
         rdy_mode = 0;
      end

      repeat (5) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
